// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a requester and the bit-serial adder controller.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input  busy, done, sum, cout);
    modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full adder, LSB first, one bit per clock,
// with a start/done handshake and registered result.

// One-bit gate-level full adder shared by every bit position.
module addbit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);
    logic n1, n2, n3;

    xor x1 (n1, a, b);
    xor x2 (sum, n1, ci);
    and a1 (n2, a, b);
    and a2 (n3, n1, ci);
    or  o1 (co, n2, n3);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    serial_add_ctrl_if.slave bus
);
    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] opa, opb, acc, acc_nxt;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt;
    logic             busy_q, done_q;
    logic             s, co;
    logic             last;

    addbit u_addbit (
        .a   (opa[0]),
        .b   (opb[0]),
        .ci  (carry_q),
        .sum (s),
        .co  (co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at acc[0].
    // Written as a truncated shift so WIDTH=1 needs no special slice.
    assign acc_nxt = WIDTH'({s, acc} >> 1);
    assign last    = (cnt == LAST);

    // Next-state logic: RUN ends on the edge that consumes the MSB.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = RUN;
            RUN:     if (last)      state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register; busy/done registered from next state so outputs come straight from flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= (state_n == RUN);
            done_q <= (state_n == DONE);
        end
    end

    // Operand/accumulator shifting, carry chain across cycles, and result capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opa     <= '0;
            opb     <= '0;
            acc     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opa     <= bus.a;
                        opb     <= bus.b;
                        carry_q <= bus.cin;
                        cnt     <= '0;
                        acc     <= '0;
                    end
                end
                RUN: begin
                    acc     <= acc_nxt;
                    opa     <= opa >> 1;
                    opb     <= opb >> 1;
                    carry_q <= co;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        sum_q  <= acc_nxt;
                        cout_q <= co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8.slave));
    serial_add_ctrl #(.WIDTH(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

    // Launch a start on bus8 so it is sampled at the next rising edge (E0).
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        @(negedge clock);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
        @(posedge clock);
        #1;
        bus8.start = 1'b0; bus8.a = ~a; bus8.b = ~b; bus8.cin = ~cin;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            bad++; $display("FAIL reset_flags8 busy=%b done=%b exp 0 0", bus8.busy, bus8.done);
        end
        total++;
        if (bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
            bad++; $display("FAIL reset_result8 sum=%h cout=%b exp 00 0", bus8.sum, bus8.cout);
        end
        total++;
        if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.sum !== 1'b0 || bus1.cout !== 1'b0) begin
            bad++; $display("FAIL reset_w1 busy=%b done=%b sum=%b cout=%b exp 0000",
                            bus1.busy, bus1.done, bus1.sum, bus1.cout);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Single operation with full cycle-by-cycle handshake checks.
    task automatic test_add(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input logic [7:0] esum, input logic ecout);
        int busy_bad = 0;
        launch8(a, b, cin);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) busy_bad++;
        end
        total++;
        if (busy_bad != 0) begin
            bad++; $display("FAIL %s_busy_window bad_cycles=%0d exp 0", nm, busy_bad);
        end
        @(negedge clock);
        total++;
        if (bus8.done !== 1'b1 || bus8.busy !== 1'b0) begin
            bad++; $display("FAIL %s_done_pulse done=%b busy=%b exp 1 0", nm, bus8.done, bus8.busy);
        end
        total++;
        if (bus8.sum !== esum || bus8.cout !== ecout) begin
            bad++; $display("FAIL %s_result sum=%h cout=%b exp %h %b", nm, bus8.sum, bus8.cout, esum, ecout);
        end
        @(negedge clock);
        total++;
        if (bus8.done !== 1'b0 || bus8.sum !== esum || bus8.cout !== ecout) begin
            bad++; $display("FAIL %s_after_done done=%b sum=%h cout=%b exp 0 %h %b",
                            nm, bus8.done, bus8.sum, bus8.cout, esum, ecout);
        end
    endtask

    task automatic test_ignore_start;
        int dones = 0;
        launch8(8'h0F, 8'h01, 1'b0);
        repeat (3) @(negedge clock);
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1;
        @(posedge clock);
        #1;
        bus8.start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus8.done === 1'b1) dones++;
        end
        total++;
        if (dones != 1) begin
            bad++; $display("FAIL ignore_done_count got=%0d exp 1", dones);
        end
        total++;
        if (bus8.sum !== 8'h10 || bus8.cout !== 1'b0 || bus8.busy !== 1'b0) begin
            bad++; $display("FAIL ignore_result sum=%h cout=%b busy=%b exp 10 0 0",
                            bus8.sum, bus8.cout, bus8.busy);
        end
    endtask

    task automatic test_back_to_back;
        launch8(8'h5A, 8'h3C, 1'b0);
        repeat (9) @(negedge clock);
        total++;
        if (bus8.done !== 1'b1 || bus8.sum !== 8'h96) begin
            bad++; $display("FAIL b2b_first done=%b sum=%h exp 1 96", bus8.done, bus8.sum);
        end
        // start raised during DONE: must be dropped
        bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0;
        @(negedge clock);
        total++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h96) begin
            bad++; $display("FAIL b2b_done_start busy=%b done=%b sum=%h exp 0 0 96",
                            bus8.busy, bus8.done, bus8.sum);
        end
        // still asserted in IDLE with new operands: accepted
        bus8.a = 8'h02; bus8.b = 8'h03;
        @(posedge clock);
        #1;
        bus8.start = 1'b0; bus8.a = 8'hAA; bus8.b = 8'hAA;
        @(negedge clock);
        total++;
        if (bus8.busy !== 1'b1 || bus8.sum !== 8'h96) begin
            bad++; $display("FAIL b2b_accept busy=%b sum=%h exp 1 96", bus8.busy, bus8.sum);
        end
        repeat (7) @(negedge clock);
        total++;
        if (bus8.done !== 1'b0 || bus8.sum !== 8'h96) begin
            bad++; $display("FAIL b2b_hold done=%b sum=%h exp 0 96", bus8.done, bus8.sum);
        end
        @(negedge clock);
        total++;
        if (bus8.done !== 1'b1 || bus8.sum !== 8'h05 || bus8.cout !== 1'b0) begin
            bad++; $display("FAIL b2b_second done=%b sum=%h cout=%b exp 1 05 0",
                            bus8.done, bus8.sum, bus8.cout);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_run;
        int dones = 0;
        launch8(8'h77, 8'h11, 1'b1);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
            bad++; $display("FAIL midrst_async busy=%b done=%b sum=%h cout=%b exp 0 0 00 0",
                            bus8.busy, bus8.done, bus8.sum, bus8.cout);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL midrst_no_done active_cycles=%0d exp 0", dones);
        end
        test_add("midrst_restart", 8'h11, 8'h22, 1'b1, 8'h34, 1'b0);
    endtask

    task automatic test_width1;
        @(negedge clock);
        bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
        @(posedge clock);
        #1;
        bus1.start = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0;
        @(negedge clock);
        total++;
        if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
            bad++; $display("FAIL w1_busy busy=%b done=%b exp 1 0", bus1.busy, bus1.done);
        end
        @(negedge clock);
        total++;
        if (bus1.done !== 1'b1 || bus1.busy !== 1'b0 || bus1.sum !== 1'b1 || bus1.cout !== 1'b1) begin
            bad++; $display("FAIL w1_result done=%b busy=%b sum=%b cout=%b exp 1 0 1 1",
                            bus1.done, bus1.busy, bus1.sum, bus1.cout);
        end
        @(negedge clock);
        total++;
        if (bus1.done !== 1'b0 || bus1.sum !== 1'b1) begin
            bad++; $display("FAIL w1_after done=%b sum=%b exp 0 1", bus1.done, bus1.sum);
        end
    endtask

    initial begin
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        test_reset();
        test_add("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        test_add("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        test_add("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        test_add("mixed", 8'hA5, 8'hC3, 1'b1, 8'h69, 1'b1);
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
